// File: rtl/imem_responder.sv
// imem_responder: instruction store with loader port and a modelled read latency.
// The fetch stage sees stall until dout is valid for the presented address.
module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  output logic [31:0] dout,
  output logic        stall,
  output logic        addr_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_off;
  logic [31:0]      ld_off;
  logic             rd_in_range;
  logic             ld_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ld_idx;
  logic [31:0]      rd_word;
  logic             unused_off_bits;

  // Map fetch and loader byte addresses onto word indices of the store.
  always_comb begin
    rd_off      = addr - BASE_ADDR;
    ld_off      = load_addr - BASE_ADDR;
    rd_in_range = (rd_off[31:IDX_W+2] == '0);
    ld_in_range = (ld_off[31:IDX_W+2] == '0);
    rd_idx      = rd_off[IDX_W+1:2];
    ld_idx      = ld_off[IDX_W+1:2];
    rd_word     = rd_in_range ? mem[rd_idx] : 32'h0000_0000;
    addr_fault  = (addr[1:0] != 2'b00) || !rd_in_range;
  end

  // Byte-offset bits do not select a word.
  assign unused_off_bits = ^{rd_off[1:0], ld_off[1:0]};

  // Loader writes; out-of-range writes are dropped. Store is never reset.
  always_ff @(posedge clk) begin
    if (load_we && ld_in_range) begin
      mem[ld_idx] <= load_data;
    end
  end

  if (LATENCY == 0) begin : g_comb

    // Purely combinational read, no stall.
    always_comb begin
      stall = 1'b0;
      dout  = reset_n ? rd_word : 32'h0000_0000;
    end

  end else begin : g_fsm

    typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_VALID = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] tag_q;
    logic [31:0] tag_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [31:0] cap_word;
    logic [31:0] tag_off;
    logic [31:0] pend_off;
    logic        hit;
    logic        inval;
    logic        unused_tag_bits;

    // Hit detection, capture bypass for a same-edge write, and loader invalidation.
    always_comb begin
      tag_off  = tag_q - BASE_ADDR;
      pend_off = pend_q - BASE_ADDR;
      hit      = (state_q == S_VALID) && (addr == tag_q);
      cap_word = (load_we && ld_in_range && rd_in_range && (ld_idx == rd_idx))
                 ? load_data : rd_word;
      inval    = load_we && ld_in_range &&
                 (((state_q == S_VALID) && (ld_off[31:2] == tag_off[31:2])) ||
                  ((state_q == S_BUSY)  && (ld_off[31:2] == pend_off[31:2])));
    end

    assign unused_tag_bits = ^{tag_off[1:0], pend_off[1:0]};

    // State and datapath registers.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        tag_q   <= '0;
        pend_q  <= '0;
        cnt_q   <= '0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        tag_q   <= tag_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        data_q  <= data_d;
      end
    end

    // Next-state: miss cycles start a read, BUSY counts down or restarts on redirect.
    always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
        S_IDLE, S_VALID: begin
          if (!hit) begin
            if (LATENCY == 1) begin
              data_d  = cap_word;
              tag_d   = addr;
              state_d = S_VALID;
            end else begin
              pend_d  = addr;
              cnt_d   = 3'd1;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (addr != pend_q) begin
            pend_d = addr;
            cnt_d  = 3'd1;
          end else if (cnt_q == 3'(LATENCY - 1)) begin
            data_d  = cap_word;
            tag_d   = addr;
            state_d = S_VALID;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (inval) begin
        state_d = S_IDLE;
      end
    end

    // Outputs: stall on any non-hit cycle, both forced low during reset.
    always_comb begin
      stall = 1'b0;
      dout  = 32'h0000_0000;
      if (reset_n) begin
        stall = !hit;
        dout  = data_q;
      end
    end

  end

endmodule
